// File: rtl/venus_pkg.sv
// Shared constants for the venus core: default widths, opcodes, instruction field positions
// and decoded-info bit indices. Define VENUS_MUL_EN to decode opcode 14 as MUL.
package venus_pkg;
  localparam int WORD_DEF = 32;
  localparam int ADDR_DEF = 16;
  localparam int RF_AW    = 4;

`ifdef VENUS_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLL  = 6'd6;
  localparam logic [5:0] OP_SRL  = 6'd7;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LUI  = 6'd9;
  localparam logic [5:0] OP_LD   = 6'd10;
  localparam logic [5:0] OP_ST   = 6'd11;
  localparam logic [5:0] OP_BEQ  = 6'd12;
  localparam logic [5:0] OP_JMP  = 6'd13;
  localparam logic [5:0] OP_MUL  = 6'd14;
  localparam logic [5:0] OP_HLT  = 6'd63;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 18;
  localparam int RT_HI  = 17;
  localparam int RT_LO  = 14;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int WRSV   = 0;
  localparam int BRF    = 1;
  localparam int HLTF   = 2;
  localparam int INFO_W = 3;

  function automatic logic [INFO_W-1:0] decode_info(input logic [5:0] opc);
    logic [INFO_W-1:0] info;
    info = '0;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
      OP_ADDI, OP_LUI, OP_LD: info[WRSV] = 1'b1;
      OP_MUL:                 info[WRSV] = MUL_EN;
      OP_BEQ, OP_JMP:         info[BRF]  = 1'b1;
      OP_HLT:                 info[HLTF] = 1'b1;
      OP_NOP:                 info       = '0;
      default:                info       = '0;
    endcase
    return info;
  endfunction
endpackage

// File: rtl/venus_regfile.sv
// 16-entry register file, two combinational reads, one write; a read of the entry being
// written this cycle returns the new value so back-to-back dependents need no stall.
module venus_regfile
  import venus_pkg::*;
#(
  parameter int W = WORD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RF_AW-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [RF_AW-1:0] raddr0,
  input  logic [RF_AW-1:0] raddr1,
  output logic [W-1:0]     rdata0,
  output logic [W-1:0]     rdata1
);
  logic [W-1:0] data1, data2, data3, data4, data5, data6, data7, data8;
  logic [W-1:0] data9, data10, data11, data12, data13, data14, data15, data16;
  logic [15:0][W-1:0] ents, ents_d;

  assign ents = {data16, data15, data14, data13, data12, data11, data10, data9,
                 data8, data7, data6, data5, data4, data3, data2, data1};

  always_comb begin
    ents_d = ents;
    if (we) ents_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {data16, data15, data14, data13, data12, data11, data10, data9,
       data8, data7, data6, data5, data4, data3, data2, data1} <= '0;
    end else begin
      {data16, data15, data14, data13, data12, data11, data10, data9,
       data8, data7, data6, data5, data4, data3, data2, data1} <= ents_d;
    end
  end

  assign rdata0 = (we && waddr == raddr0) ? wdata : ents[raddr0];
  assign rdata1 = (we && waddr == raddr1) ? wdata : ents[raddr1];
endmodule

// File: rtl/venus_top.sv
// Venus core: P -> F -> D/E pipeline with combinational execute and writeback at the next edge.
// Build option VENUS_MUL_EN (see venus_pkg) enables the MUL opcode.
module venus_top
  import venus_pkg::*;
#(
  parameter int WORD       = WORD_DEF,
  parameter int ADDR       = ADDR_DEF,
  parameter int DMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic [WORD-1:0] inst_i,
  output logic [ADDR-1:0] inst_addr_o
);
  localparam int DA = $clog2(DMEM_DEPTH);

  logic [ADDR-1:0]   pc_pf, pc_fd, pc_de, pc_pf_d, pc_fd_d, pc_de_d;
  logic              v_fd_q, v_fd_d, v_de, v_de_d, halted, halted_d;
  logic              hold_v_q, hold_v_d;
  logic [WORD-1:0]   inst_hold_q, inst_f;
  logic [WORD-1:0]   opr0_de, opr1_de, opr0_de_d, opr1_de_d;
  logic [15:0]       imm_de, imm_de_d;
  logic [RF_AW-1:0]  wb_r_de, wb_r_de_d;
  logic [5:0]        op_de, op_de_d;
  logic [INFO_W-1:0] d_info_de, d_info_de_d;
  logic              stall_fp, stall_df, branch_wire;

  logic [5:0]        f_opc;
  logic [RF_AW-1:0]  f_rd, f_rs, f_rt, rd_addr1;
  logic [15:0]       f_imm;
  logic [WORD-1:0]   rd_data0, rd_data1;
  logic [WORD-1:0]   imm_x, dm_rdata, alu_res;
  logic [DA-1:0]     dm_addr;
  logic [ADDR-1:0]   br_target;
  logic              rf_we, mem_we;

  // stall_i is a freeze, not a handshake: while stall_fp is high every PC, valid and stage
  // register holds and no register or memory write happens; the F-stage word is replayed.
  assign stall_fp    = stall_i | halted;
  assign stall_df    = stall_fp;
  assign inst_addr_o = pc_pf;

  always_comb begin
    inst_f   = hold_v_q ? inst_hold_q : inst_i;
    f_opc    = inst_f[OPC_HI:OPC_LO];
    f_rd     = inst_f[RD_HI:RD_LO];
    f_rs     = inst_f[RS_HI:RS_LO];
    f_rt     = inst_f[RT_HI:RT_LO];
    f_imm    = inst_f[IMM_HI:IMM_LO];
    // ST and BEQ use rd as a source operand
    rd_addr1 = (f_opc == OP_ST || f_opc == OP_BEQ) ? f_rd : f_rt;
  end

  venus_regfile #(.W(WORD)) register (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (wb_r_de),
    .wdata  (alu_res),
    .raddr0 (f_rs),
    .raddr1 (rd_addr1),
    .rdata0 (rd_data0),
    .rdata1 (rd_data1)
  );

  assign imm_x   = {{(WORD-16){imm_de[15]}}, imm_de};
  assign dm_addr = DA'(opr0_de + imm_x);

  always_comb begin
    alu_res = '0;
    case (op_de)
      OP_ADD:  alu_res = opr0_de + opr1_de;
      OP_SUB:  alu_res = opr0_de - opr1_de;
      OP_AND:  alu_res = opr0_de & opr1_de;
      OP_OR:   alu_res = opr0_de | opr1_de;
      OP_XOR:  alu_res = opr0_de ^ opr1_de;
      OP_SLL:  alu_res = opr0_de << opr1_de[4:0];
      OP_SRL:  alu_res = opr0_de >> opr1_de[4:0];
      OP_ADDI: alu_res = opr0_de + imm_x;
      OP_LUI:  alu_res = {imm_de, {(WORD-16){1'b0}}};
      OP_LD:   alu_res = dm_rdata;
      OP_MUL:  alu_res = MUL_EN ? opr0_de * opr1_de : '0;
      default: alu_res = '0;
    endcase
    branch_wire = v_de && d_info_de[BRF] && (op_de == OP_JMP || opr1_de == opr0_de);
    br_target   = (op_de == OP_JMP) ? ADDR'(imm_x) : pc_de + ADDR'(imm_x);
    rf_we       = v_de && d_info_de[WRSV] && !stall_df;
    mem_we      = v_de && (op_de == OP_ST) && !stall_df;
  end

  always_comb begin
    pc_pf_d     = pc_pf;
    pc_fd_d     = pc_fd;
    v_fd_d      = v_fd_q;
    pc_de_d     = pc_de;
    v_de_d      = v_de;
    opr0_de_d   = opr0_de;
    opr1_de_d   = opr1_de;
    imm_de_d    = imm_de;
    wb_r_de_d   = wb_r_de;
    op_de_d     = op_de;
    d_info_de_d = d_info_de;
    hold_v_d    = stall_fp;
    halted_d    = halted | (v_de && d_info_de[HLTF] && !stall_df);
    if (!stall_fp) begin
      pc_pf_d     = pc_pf + 1'b1;
      pc_fd_d     = pc_pf;
      v_fd_d      = 1'b1;
      pc_de_d     = pc_fd;
      v_de_d      = v_fd_q;
      opr0_de_d   = rd_data0;
      opr1_de_d   = rd_data1;
      imm_de_d    = f_imm;
      wb_r_de_d   = f_rd;
      op_de_d     = f_opc;
      d_info_de_d = decode_info(f_opc);
      if (branch_wire) begin
        pc_pf_d = br_target;
        v_fd_d  = 1'b0;
        v_de_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_pf       <= '0;
      pc_fd       <= '0;
      pc_de       <= '0;
      v_fd_q      <= 1'b0;
      v_de        <= 1'b0;
      halted      <= 1'b0;
      hold_v_q    <= 1'b0;
      inst_hold_q <= '0;
      opr0_de     <= '0;
      opr1_de     <= '0;
      imm_de      <= '0;
      wb_r_de     <= '0;
      op_de       <= '0;
      d_info_de   <= '0;
    end else begin
      pc_pf       <= pc_pf_d;
      pc_fd       <= pc_fd_d;
      pc_de       <= pc_de_d;
      v_fd_q      <= v_fd_d;
      v_de        <= v_de_d;
      halted      <= halted_d;
      hold_v_q    <= hold_v_d;
      inst_hold_q <= inst_f;
      opr0_de     <= opr0_de_d;
      opr1_de     <= opr1_de_d;
      imm_de      <= imm_de_d;
      wb_r_de     <= wb_r_de_d;
      op_de       <= op_de_d;
      d_info_de   <= d_info_de_d;
    end
  end

  if (1) begin : mem_rw
    logic [WORD-1:0] mem_bank [DMEM_DEPTH];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DMEM_DEPTH; i++) mem_bank[i] <= '0;
      end else if (mem_we) begin
        mem_bank[dm_addr] <= opr1_de;
      end
    end
    assign dm_rdata = mem_bank[dm_addr];
  end
endmodule

// File: tb/tb_venus_top.sv
// Directed bench for venus_top: bypass, load/store with address wrap, branch/jump bubbles,
// stall freeze and replay, stall-vs-branch priority, halt and reset restart.
module tb_venus_top;
  import venus_pkg::*;

  localparam int WORD = 32;
  localparam int ADDR = 16;

`ifdef VENUS_MUL_EN
  localparam logic [31:0] MUL_RES = 32'd40;
`else
  localparam logic [31:0] MUL_RES = 32'd0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall_i = 1'b0;
  logic [WORD-1:0] inst_i;
  logic [ADDR-1:0] inst_addr_o;
  logic [31:0]     imem [64];

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          hc;

  logic [31:0] trace_tbl [9] = '{32'h0_0000, 32'h0_0000, 32'h1_0000, 32'h1_0001, 32'h1_0002,
                                 32'h0_0003, 32'h0_0004, 32'h1_0005, 32'h1_0006};
  logic [31:0] exp_rf [16] = '{32'd0, 32'd5, 32'd8, 32'd13, 32'd13, MUL_RES, 32'd0, 32'd0,
                               32'd3, 32'd1280, 32'h1234_0000, 32'd8, 32'd0, 32'hFFFF_FFFF,
                               32'd13, 32'h07FF_FFFF};

  venus_top dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .inst_i      (inst_i),
    .inst_addr_o (inst_addr_o)
  );

  // clock and synchronous instruction memory (1-cycle read latency)
  always #5 clk = ~clk;
  always @(posedge clk) inst_i <= imem[inst_addr_o[5:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt, 14'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 2'b0, imm};
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load_prog_a();
    for (int i = 0; i < 64; i++) imem[i] = '0;
    imem[0] = enc_i(OP_ADDI, 4'd1, 4'd0, 16'd5);
    imem[1] = enc_i(OP_ADDI, 4'd2, 4'd1, 16'd3);
    imem[2] = enc_i(OP_BEQ,  4'd0, 4'd0, 16'd3);
    imem[3] = enc_i(OP_ADDI, 4'd6, 4'd0, 16'd99);
    imem[4] = enc_i(OP_ADDI, 4'd7, 4'd0, 16'd99);
    imem[5] = enc_r(OP_ADD,  4'd3, 4'd1, 4'd2);
    imem[6] = {OP_HLT, 26'b0};
  endtask

  task automatic load_prog_b();
    for (int i = 0; i < 64; i++) imem[i] = '0;
    imem[0]  = enc_i(OP_ADDI, 4'd1,  4'd0,  16'd5);
    imem[1]  = enc_i(OP_ADDI, 4'd2,  4'd1,  16'd3);
    imem[2]  = enc_r(OP_ADD,  4'd3,  4'd1,  4'd2);
    imem[3]  = enc_i(OP_ST,   4'd3,  4'd0,  16'd4);
    imem[4]  = enc_i(OP_LD,   4'd4,  4'd0,  16'd4);
    imem[5]  = enc_r(OP_MUL,  4'd5,  4'd1,  4'd2);
    imem[6]  = enc_r(OP_SUB,  4'd8,  4'd2,  4'd1);
    imem[7]  = enc_r(OP_SLL,  4'd9,  4'd1,  4'd2);
    imem[8]  = enc_i(OP_LUI,  4'd10, 4'd0,  16'h1234);
    imem[9]  = enc_r(OP_XOR,  4'd11, 4'd3,  4'd1);
    imem[10] = enc_i(OP_LD,   4'd14, 4'd0,  16'd260);
    imem[11] = enc_i(OP_JMP,  4'd0,  4'd0,  16'd13);
    imem[12] = enc_i(OP_ADDI, 4'd12, 4'd0,  16'd1);
    imem[13] = enc_i(OP_ADDI, 4'd13, 4'd0,  16'hFFFF);
    imem[14] = enc_r(OP_SRL,  4'd15, 4'd13, 4'd1);
    imem[15] = {OP_HLT, 26'b0};
  endtask

  // Runs from reset release until halted (bounded); optional stall window with frozen-state checks.
  task automatic run_prog(input int budget, input int stall_start, input int stall_len,
                          input int exp_pf, input int exp_de, input int chk_r,
                          output int halt_cyc);
    int c;
    c = 0;
    halt_cyc = -1;
    while (c < budget) begin
      @(negedge clk);
      if (stall_len > 0 && c > stall_start && c <= stall_start + stall_len) begin
        check_eq("stall_pc_pf", 32'(dut.pc_pf), 32'(exp_pf));
        check_eq("stall_pc_de", 32'(dut.pc_de), 32'(exp_de));
        check_eq("stall_no_write", dut.register.ents[chk_r], 32'd0);
      end
      if (dut.halted) begin
        halt_cyc = c;
        break;
      end
      stall_i = (stall_len > 0) && (c >= stall_start) && (c < stall_start + stall_len);
      c++;
    end
    stall_i = 1'b0;
    check_eq("halt_reached", 32'(dut.halted), 32'd1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("%s_r%0d", tag, i), dut.register.ents[i], exp_rf[i]);
  endtask

  initial begin
    // Program A: bypass, BEQ bubbles, halt freeze
    load_prog_a();
    do_reset();
    for (int i = 0; i < 9; i++) exp_q.push_back(trace_tbl[i]);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq("reset_inst_addr", 32'(inst_addr_o), 32'd0);
        check_eq("reset_halted", 32'(dut.halted), 32'd0);
      end
      check_eq($sformatf("de_trace_c%0d", c), {15'b0, dut.v_de, dut.pc_de}, exp_q.pop_front());
    end
    @(negedge clk);
    check_eq("a_halted", 32'(dut.halted), 32'd1);
    check_eq("a_halt_pc_pf", 32'(dut.pc_pf), 32'd9);
    check_eq("a_r1", dut.register.data2, 32'd5);
    check_eq("a_r2", dut.register.data3, 32'd8);
    check_eq("a_r3", dut.register.data4, 32'd13);
    check_eq("a_r6_flushed", dut.register.data7, 32'd0);
    check_eq("a_r7_flushed", dut.register.data8, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_eq("a_frozen_pc_pf", 32'(dut.pc_pf), 32'd9);
    end
    check_eq("a_frozen_r3", dut.register.data4, 32'd13);
    check_eq("a_frozen_r2", dut.register.data3, 32'd8);

    // Reset after halt restarts at pc 0 with cleared registers
    do_reset();
    @(negedge clk);
    check_eq("rst_inst_addr", 32'(inst_addr_o), 32'd0);
    check_eq("rst_halted", 32'(dut.halted), 32'd0);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("rst_r%0d", i), dut.register.ents[i], 32'd0);
    repeat (2) @(negedge clk);
    check_eq("restart_de", {15'b0, dut.v_de, dut.pc_de}, 32'h1_0000);

    // Program B: unstalled reference run
    load_prog_b();
    do_reset();
    run_prog(60, 0, 0, 0, 0, 0, hc);
    check_eq("b_halt_cycle", 32'(hc), 32'd19);
    check_regs("b");
    check_eq("b_mem4", dut.mem_rw.mem_bank[4], 32'd13);

    // Program B with a 3-cycle stall early on (F-stage replay, write suppression)
    do_reset();
    run_prog(60, 3, 3, 3, 1, 2, hc);
    check_eq("stall_halt_cycle", 32'(hc), 32'd22);
    check_regs("stall");

    // Program B with a stall that coincides with the JMP in E
    do_reset();
    run_prog(60, 13, 2, 13, 11, 13, hc);
    check_eq("brstall_halt_cycle", 32'(hc), 32'd21);
    check_regs("brstall");

    // Reset clears data memory
    do_reset();
    @(negedge clk);
    check_eq("rst_mem4", dut.mem_rw.mem_bank[4], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
